// File: rtl/mult_shift_add_if.sv
// Start/done handshake and operand/result bus for the shift-add multiplier.
interface mult_shift_add_if #(
    parameter int WIDTH = 8
);
    logic               start;
    logic               sgn;
    logic [WIDTH-1:0]   multiplicand;
    logic [WIDTH-1:0]   multiplier;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;

    modport master (
        output start, sgn, multiplicand, multiplier,
        input  busy, done, product
    );

    modport slave (
        input  start, sgn, multiplicand, multiplier,
        output busy, done, product
    );
endinterface

// File: rtl/mult_shift_add.sv
// Sequential WIDTH x WIDTH shift-add multiplier with sign handling.
// One add-and-shift step per clock over a (2W+1)-bit accumulator.
module mult_shift_add #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    mult_shift_add_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_e;

    state_e               state_q, state_d;
    logic [2*WIDTH:0]     acc_q, acc_d;
    logic [WIDTH-1:0]     mc_q, mc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 neg_q, neg_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;

    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   p;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            mc_q      <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mc_q      <= mc_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            product_q <= product_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mc_d      = mc_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        product_d = product_q;
        done_d    = 1'b0;
        mag_a     = bus.multiplicand;
        mag_b     = bus.multiplier;
        sum       = acc_q[2*WIDTH:WIDTH];
        p         = acc_q[2*WIDTH-1:0];

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    // most-negative input negates to 2^(W-1), still fits unsigned
                    if (bus.sgn && bus.multiplicand[WIDTH-1])
                        mag_a = ~bus.multiplicand + WIDTH'(1);
                    if (bus.sgn && bus.multiplier[WIDTH-1])
                        mag_b = ~bus.multiplier + WIDTH'(1);
                    neg_d   = bus.sgn &
                              (bus.multiplicand[WIDTH-1] ^ bus.multiplier[WIDTH-1]);
                    acc_d   = {{(WIDTH+1){1'b0}}, mag_b};
                    mc_d    = mag_a;
                    cnt_d   = CW'(WIDTH);
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (acc_q[0])
                    sum = acc_q[2*WIDTH:WIDTH] + {1'b0, mc_q};
                acc_d = {1'b0, sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1))
                    state_d = S_FIX;
            end
            S_FIX: begin
                product_d = neg_q ? (~p + (2*WIDTH)'(1)) : p;
                done_d    = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;
endmodule

// File: doc/mult_shift_add.md
# mult_shift_add

Parametrised sequential shift-add multiplier: a WIDTH-by-WIDTH multiply built around one internal (2·WIDTH+1)-bit accumulator/shift register, with its own control FSM, start/done handshake and signed/unsigned mode. It is the datapath-plus-controller successor of the fixed 9-bit accumulator used in the multiplier. The integer multiply path of the MIPS core instantiates it and stalls on `busy`.

## Interface

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  reset, synchronous, active-low; sampled on the rising edge of clk.
- start  input  1  request a multiply; honoured only in IDLE.
- sgn  input  1  1 = two's-complement operands, 0 = unsigned; captured with start.
- multiplicand  input  WIDTH  operand A; captured with start.
- multiplier  input  WIDTH  operand B; captured with start.
- busy  output  1  high in RUN and FIX.
- done  output  1  single-cycle pulse when product is updated.
- product  output  2·WIDTH  result; held until the next completed multiply.

## Operation

- Internal state:
  - ACC[2W:0] (W = WIDTH): upper part ACC[2W:W] is W+1 bits, lower part ACC[W-1:0] is W bits.
  - MC: W-bit multiplicand magnitude.
  - cnt: down-counter of ceil(log2(W+1)) bits.
  - neg: result sign flag.
- FSM states: IDLE, RUN, FIX.
- IDLE, start=1:
  - With sgn=1, take the magnitude of each operand (two's-complement negate when its MSB is 1) and set neg = A[W-1] XOR B[W-1].
  - With sgn=0, use the raw operands and set neg=0.
  - Load ACC = {0, |B|}, MC = |A|, cnt = W. Go to RUN.
- IDLE, start=0: hold.
- RUN, one step per clock:
  - If ACC[0]=1, form sum = ACC[2W:W] + {0,MC} (W+1 bits; the carry is kept in bit 2W). Otherwise sum = ACC[2W:W].
  - Load ACC = {0, sum, ACC[W-1:1]}. This is an add followed by a logical right shift in the same edge.
  - Decrement cnt. When cnt is 1 at this edge, go to FIX.
- FIX:
  - Take P = ACC[2W-1:0].
  - Write product = neg ? (−P mod 2^(2W)) : P.
  - Pulse done=1 for exactly the following cycle.
  - Go to IDLE.
- `start` while busy is ignored. It is not queued and does not disturb the operation in flight.
- Operand and `sgn` inputs are don't-care after the capture edge.
- Magnitude of the most-negative value (−2^(W−1)) is 2^(W−1), which is representable as W-bit unsigned. The result is therefore exact for all inputs; no overflow is possible in 2W bits.
- Zero operand: the full sequence still runs and product = 0. neg may be 1, and −0 = 0.

## Timing

- Reset (rst_n=0 at an edge): state=IDLE, busy=0, done=0, product=0, and ACC/MC/cnt/neg are cleared.
- Reset mid-operation aborts immediately. No done pulse; product returns to 0.
- Call edge 0 the edge that samples start=1 in IDLE.
  - busy rises after edge 0.
  - RUN occupies edges 1..W.
  - FIX executes at edge W+1: product is updated and done=1 with busy=0 after that edge.
  - done falls after edge W+2.
- Latency: start-to-done is W+1 cycles. W=8 gives done visible 9 cycles after start is sampled.
- Throughput: one multiply per W+2 cycles. A start held high in the cycle where done=1 is accepted at the next edge.
- done and product change only on FIX edges or reset; product is stable at all other times.
- busy is registered and low exactly when state=IDLE.

## Test plan

- Reset/idle:
  - Stimulus: hold rst_n=0 for 2 edges with start=1, then release with start=0.
  - Required: product=0, busy=0, done=0 throughout; no operation starts.
- Unsigned basic, WIDTH=8, sgn=0:
  - Stimulus: A=0xAC, B=0x0B, start for one cycle.
  - Required: done pulses after edge 9 with product=0x0764 (172·11=1892), and busy is high for exactly 9 cycles.
- Unsigned extremes, sgn=0:
  - Stimulus: 0xFF·0xFF, then 0x00·0xFF.
  - Required: product is 0xFE01, then 0x0000; each result is accompanied by a single done pulse.
- Signed, sgn=1:
  - Stimulus: −3·5 (0xFD, 0x05), then −128·−128 (0x80, 0x80), then 127·−128 (0x7F, 0x80).
  - Required: product is 0xFFF1, then 0x4000, then 0xC080.
- Handshake:
  - Stimulus: during busy, change A/B and assert start. Then hold start high through the done cycle with new operands 2·3.
  - Required: first result unaffected. The second multiply starts on the edge after done, and product becomes 0x0006 W+1 cycles later.
- Abort and parameter sweep:
  - Stimulus: drive rst_n=0 at RUN edge 4 of 0xAC·0x0B.
  - Required: busy=0 and product=0 after that edge, with no done pulse.
  - Also: repeat random signed/unsigned vectors for WIDTH=2, 5 and 16 against a reference model.
